// File: rtl/portal_bridge_pkg.sv
// Shared types and constants for the portal host bridge.
// Holds the FSM encoding, address regions, register offsets and error bits.
package portal_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ_WAIT = 2'd1,
        S_IND_WAIT = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    localparam logic [1:0] RGN_REQ  = 2'd0;
    localparam logic [1:0] RGN_IND  = 2'd1;
    localparam logic [1:0] RGN_CTRL = 2'd2;
    localparam logic [1:0] RGN_BAD  = 2'd3;

    localparam logic [1:0] CTRL_INTR = 2'd0;
    localparam logic [1:0] CTRL_ERR  = 2'd1;
    localparam logic [1:0] CTRL_IEN  = 2'd2;

    localparam int ERR_REQ_TO  = 0;
    localparam int ERR_IND_TO  = 1;
    localparam int ERR_BAD_CH  = 2;
    localparam int ERR_BAD_RGN = 3;

endpackage

// File: rtl/portal_host_bridge.sv
// Memory-mapped host initiator for the portal request/indication ports.
// One transaction at a time: accept, wait for RDY (bounded), respond.
module portal_host_bridge
    import portal_bridge_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int NUM_IND = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wr_valid,
    input  logic [7:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    input  logic        rd_valid,
    input  logic [7:0]  rd_addr,
    output logic        rd_data_valid,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic [31:0] requestEnqV,
    output logic        EN_request,
    output logic [1:0]  selectRequest,
    input  logic        RDY_requestEnq,
    output logic        EN_indication,
    output logic [1:0]  selectIndication,
    input  logic [31:0] indicationData,
    input  logic        RDY_indication,
    input  logic [31:0] indIntrChannel,
    output logic        intr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] LP_NREQ = 3'(NUM_REQ);
    localparam logic [2:0] LP_NIND = 3'(NUM_IND);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_is_wr;
    logic [31:0]   r_resp;
    logic [31:0]   r_rd_hold;
    logic [3:0]    r_err;
    logic          r_ien;

    logic          w_acc;
    logic          w_wr;
    logic [7:0]    w_addr;
    logic [1:0]    w_rgn;
    logic [1:0]    w_ch;
    logic          w_ctrl;
    logic          w_go_req;
    logic          w_go_ind;
    logic          w_bad_ch;
    logic          w_bad_rgn;
    logic          w_to;
    logic [31:0]   w_ctrl_rd;
    logic [3:0]    w_err_set;
    logic [3:0]    w_err_clr;
    logic          w_unused_addr;

    // Write wins when both requests arrive together.
    assign w_acc  = wr_valid | rd_valid;
    assign w_wr   = wr_valid;
    assign w_addr = wr_valid ? wr_addr : rd_addr;
    assign w_rgn  = w_addr[7:6];
    assign w_ch   = w_addr[3:2];
    assign w_ctrl = (w_rgn == RGN_CTRL);
    assign w_unused_addr = ^{w_addr[5:4], w_addr[1:0]};

    assign w_go_req = w_wr & (w_rgn == RGN_REQ)
                    & ({1'b0, w_ch} < LP_NREQ);
    assign w_go_ind = ~w_wr & (w_rgn == RGN_IND)
                    & ({1'b0, w_ch} < LP_NIND);
    assign w_bad_ch = (w_wr & (w_rgn == RGN_REQ) & ~w_go_req)
                    | (~w_wr & (w_rgn == RGN_IND) & ~w_go_ind);
    assign w_bad_rgn = (w_rgn == RGN_BAD)
                     | (w_wr & (w_rgn == RGN_IND))
                     | (~w_wr & (w_rgn == RGN_REQ));

    assign w_to = (r_cnt == CW'(TIMEOUT));

    always_comb begin
        case (w_ch)
            CTRL_INTR: w_ctrl_rd = indIntrChannel;
            CTRL_ERR:  w_ctrl_rd = {28'd0, r_err};
            CTRL_IEN:  w_ctrl_rd = {31'd0, r_ien};
            default:   w_ctrl_rd = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (w_go_req)      w_state_nxt = S_REQ_WAIT;
                    else if (w_go_ind) w_state_nxt = S_IND_WAIT;
                    else               w_state_nxt = S_RESP;
                end
            end
            S_REQ_WAIT: begin
                if (RDY_requestEnq | w_to) w_state_nxt = S_RESP;
            end
            S_IND_WAIT: begin
                if (RDY_indication | w_to) w_state_nxt = S_RESP;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        EN_request    = 1'b0;
        EN_indication = 1'b0;
        wr_ack        = 1'b0;
        rd_data_valid = 1'b0;
        unique case (r_state)
            S_REQ_WAIT: EN_request    = RDY_requestEnq;
            S_IND_WAIT: EN_indication = RDY_indication;
            S_RESP: begin
                wr_ack        = r_is_wr;
                rd_data_valid = ~r_is_wr;
            end
            default: ;
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign rd_data = rd_data_valid ? r_resp : r_rd_hold;

    // Timeouts only arise in wait states and W1C only in IDLE,
    // but the merge still lets a set beat a clear on the same bit.
    always_comb begin
        w_err_set = '0;
        w_err_clr = '0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_err_set[ERR_BAD_CH]  = w_bad_ch;
                    w_err_set[ERR_BAD_RGN] = w_bad_rgn;
                    if (w_wr & w_ctrl & (w_ch == CTRL_ERR))
                        w_err_clr = wr_data[3:0];
                end
            end
            S_REQ_WAIT:
                w_err_set[ERR_REQ_TO] = w_to & ~RDY_requestEnq;
            S_IND_WAIT:
                w_err_set[ERR_IND_TO] = w_to & ~RDY_indication;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt            <= '0;
            r_is_wr          <= 1'b0;
            r_resp           <= '0;
            r_rd_hold        <= '0;
            r_err            <= '0;
            r_ien            <= 1'b0;
            intr             <= 1'b0;
            requestEnqV      <= '0;
            selectRequest    <= '0;
            selectIndication <= '0;
        end else begin
            r_err <= (r_err & ~w_err_clr) | w_err_set;
            intr  <= r_ien & (indIntrChannel != 32'd0);
            if ((r_state == S_REQ_WAIT) || (r_state == S_IND_WAIT)) begin
                if (!w_to) r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_is_wr <= w_wr;
                        r_resp  <= '0;
                        if (w_go_req) begin
                            selectRequest <= w_ch;
                            requestEnqV   <= wr_data;
                        end
                        if (w_go_ind) selectIndication <= w_ch;
                        if (w_ctrl & ~w_wr) r_resp <= w_ctrl_rd;
                        if (w_ctrl & w_wr & (w_ch == CTRL_IEN))
                            r_ien <= wr_data[0];
                    end
                end
                S_IND_WAIT: begin
                    if (RDY_indication) r_resp <= indicationData;
                end
                S_RESP: begin
                    if (!r_is_wr) r_rd_hold <= r_resp;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_portal_host_bridge.sv
// Self-checking bench for portal_host_bridge.
// Directed steps plus random traffic against a cycle-count reference model.
module tb_portal_host_bridge;

    localparam int TO = 255;
    localparam int NEVER = 1000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_ack;
    logic        rd_valid = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        rd_data_valid;
    logic [31:0] rd_data;
    logic        busy;
    logic [31:0] requestEnqV;
    logic        EN_request;
    logic [1:0]  selectRequest;
    logic        RDY_requestEnq = 1'b0;
    logic        EN_indication;
    logic [1:0]  selectIndication;
    logic [31:0] indicationData = '0;
    logic        RDY_indication = 1'b0;
    logic [31:0] indIntrChannel = '0;
    logic        intr;

    portal_host_bridge #(.NUM_REQ(3), .NUM_IND(2), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack),
        .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .busy(busy),
        .requestEnqV(requestEnqV), .EN_request(EN_request),
        .selectRequest(selectRequest), .RDY_requestEnq(RDY_requestEnq),
        .EN_indication(EN_indication), .selectIndication(selectIndication),
        .indicationData(indicationData), .RDY_indication(RDY_indication),
        .indIntrChannel(indIntrChannel), .intr(intr)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0]  m_err = '0;
    logic        m_ien = 1'b0;
    logic [31:0] m_last_rd = '0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [73:0] all_outs();
        return {wr_ack, rd_data_valid, rd_data, busy, requestEnqV,
                EN_request, selectRequest, EN_indication,
                selectIndication, intr};
    endfunction

    // Behavioural model: outcome of one transaction from the address map
    // and the cycle at which RDY first appears (dly+1 after accept).
    task automatic model(input bit is_wr, input logic [7:0] addr,
                         input logic [31:0] data, input int dly,
                         input logic [31:0] ind,
                         output int lat, output int nreq, output int nind,
                         output logic [31:0] rdata);
        logic [1:0] rgn;
        logic [1:0] ch;
        rgn = addr[7:6];
        ch = addr[3:2];
        lat = 1;
        nreq = 0;
        nind = 0;
        rdata = '0;
        if (rgn == 2'd0 && is_wr) begin
            if (ch < 2'd3) begin
                if (dly <= TO) begin nreq = 1; lat = dly + 2; end
                else begin lat = TO + 2; m_err[0] = 1'b1; end
            end else m_err[2] = 1'b1;
        end else if (rgn == 2'd1 && !is_wr) begin
            if (ch < 2'd2) begin
                if (dly <= TO) begin
                    nind = 1; lat = dly + 2; rdata = ind;
                end else begin lat = TO + 2; m_err[1] = 1'b1; end
            end else m_err[2] = 1'b1;
        end else if (rgn == 2'd2) begin
            if (is_wr) begin
                if (ch == 2'd1) m_err = m_err & ~data[3:0];
                if (ch == 2'd2) m_ien = data[0];
            end else begin
                if (ch == 2'd0) rdata = indIntrChannel;
                if (ch == 2'd1) rdata = {28'd0, m_err};
                if (ch == 2'd2) rdata = {31'd0, m_ien};
            end
        end else begin
            m_err[3] = 1'b1;
        end
    endtask

    // Drives one request starting after a posedge, returns after a posedge.
    task automatic xact(input bit is_wr, input bit also_rd,
                        input logic [7:0] addr, input logic [31:0] data,
                        input int dly, input logic [31:0] ind,
                        output int lat, output int nreq, output int nind,
                        output int nack, output int nrdv, output int nbl,
                        output logic [31:0] pay, output logic [1:0] sreq,
                        output logic [1:0] sind, output int sc,
                        output logic [31:0] rdata);
        bit done;
        lat = -1; nreq = 0; nind = 0; nack = 0; nrdv = 0; nbl = 0;
        pay = '0; sreq = '0; sind = '0; sc = -1; rdata = '0;
        done = 1'b0;
        wr_valid = is_wr;
        rd_valid = !is_wr || also_rd;
        wr_addr = addr;
        rd_addr = addr;
        wr_data = data;
        @(posedge CLK);
        #1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            RDY_requestEnq = (c > dly);
            RDY_indication = (c > dly);
            indicationData = ind;
            @(negedge CLK);
            if (!busy) nbl++;
            if (EN_request) begin
                nreq++; pay = requestEnqV; sreq = selectRequest; sc = c;
            end
            if (EN_indication) begin
                nind++; sind = selectIndication; sc = c;
            end
            if (wr_ack) nack++;
            if (rd_data_valid) nrdv++;
            if (wr_ack || rd_data_valid) begin
                lat = c; rdata = rd_data; done = 1'b1;
            end
            @(posedge CLK);
            #1;
            if (done) break;
        end
        RDY_requestEnq = 1'b0;
        RDY_indication = 1'b0;
    endtask

    task automatic run(input string tag, input bit is_wr, input bit also_rd,
                       input logic [7:0] addr, input logic [31:0] data,
                       input int dly, input logic [31:0] ind);
        int el, enr, eni, lat, nreq, nind, nack, nrdv, nbl, sc;
        logic [31:0] erd, pay, rdata;
        logic [1:0] sreq, sind;
        model(is_wr, addr, data, dly, ind, el, enr, eni, erd);
        xact(is_wr, also_rd, addr, data, dly, ind, lat, nreq, nind,
             nack, nrdv, nbl, pay, sreq, sind, sc, rdata);
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_nreq"}, nreq, enr);
        chk({tag, "_nind"}, nind, eni);
        chk({tag, "_nack"}, nack, is_wr ? 1 : 0);
        chk({tag, "_nrdv"}, nrdv, is_wr ? 0 : 1);
        chk({tag, "_busy"}, nbl, 0);
        if (enr == 1) begin
            chk({tag, "_payload"}, pay, data);
            chk({tag, "_selreq"}, sreq, addr[3:2]);
            chk({tag, "_strobe_cyc"}, sc, el - 1);
        end
        if (eni == 1) chk({tag, "_selind"}, sind, addr[3:2]);
        if (!is_wr) begin
            chk({tag, "_rdata"}, rdata, erd);
            m_last_rd = erd;
        end else begin
            chk({tag, "_rd_hold"}, rd_data, m_last_rd);
        end
        chk({tag, "_intr"}, intr, m_ien & (indIntrChannel != 0));
    endtask

    initial begin
        int bad;
        logic [7:0] ra;

        RDY_requestEnq = 1'b1;
        RDY_indication = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_outs", all_outs(), 74'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        RDY_requestEnq = 1'b0;
        RDY_indication = 1'b0;
        @(negedge CLK);
        chk("idle_outs", all_outs(), 74'd0);
        @(posedge CLK);
        #1;

        run("wr_ch1", 1'b1, 1'b0, 8'h04, 32'hA5A5_0001, 0, '0);
        run("rd_ind0", 1'b0, 1'b0, 8'h40, '0, 10, 32'h1234);
        run("err_clean", 1'b0, 1'b0, 8'h84, '0, 0, '0);
        run("wr_timeout", 1'b1, 1'b0, 8'h00, 32'hDEAD_0000, NEVER, '0);
        run("err_reqto", 1'b0, 1'b0, 8'h84, '0, 0, '0);
        run("w1c_bit0", 1'b1, 1'b0, 8'h84, 32'h1, 0, '0);
        run("wr_rdy_at_to", 1'b1, 1'b0, 8'h08, 32'h0BAD_F00D, TO, '0);
        run("rd_timeout", 1'b0, 1'b0, 8'h44, '0, TO + 1, 32'h55);
        run("err_indto", 1'b0, 1'b0, 8'h84, '0, 0, '0);
        run("wr_and_rd", 1'b1, 1'b1, 8'h04, 32'h0000_BEEF, 3, '0);
        run("wr_badch", 1'b1, 1'b0, 8'h0C, 32'h7777_7777, 0, '0);
        run("rd_badch", 1'b0, 1'b0, 8'h48, '0, 0, '0);
        run("err_badch", 1'b0, 1'b0, 8'h84, '0, 0, '0);
        run("w1c_bit2", 1'b1, 1'b0, 8'h84, 32'h4, 0, '0);
        run("err_after_w1c", 1'b0, 1'b0, 8'h84, '0, 0, '0);
        run("rd_region3", 1'b0, 1'b0, 8'hC4, '0, 0, '0);
        run("wr_region1", 1'b1, 1'b0, 8'h40, 32'h1, 0, '0);
        indIntrChannel = 32'd2;
        run("ien_set", 1'b1, 1'b0, 8'h88, 32'h1, 0, '0);
        run("rd_intrch", 1'b0, 1'b0, 8'h80, '0, 0, '0);
        run("rd_ien", 1'b0, 1'b0, 8'h88, '0, 0, '0);

        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom);
            if ($urandom_range(0, 3) == 0) indIntrChannel = $urandom_range(0, 3);
            run($sformatf("rnd%0d", i), 1'($urandom), 1'b0, ra,
                $urandom, $urandom_range(0, 5), $urandom);
        end

        wr_valid = 1'b1;
        wr_addr = 8'h00;
        wr_data = 32'hCAFE_CAFE;
        @(posedge CLK);
        #1;
        wr_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        RDY_requestEnq = 1'b1;
        #1;
        chk("midwait_reset_outs", all_outs(), 74'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_err = '0;
        m_ien = 1'b0;
        m_last_rd = '0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (EN_request || wr_ack || busy) bad++;
        end
        RDY_requestEnq = 1'b0;
        chk("post_reset_quiet", bad, 0);
        @(posedge CLK);
        #1;
        run("post_reset_err", 1'b0, 1'b0, 8'h84, '0, 0, '0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
